// File: rtl/exc_commit_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// exc_commit_ctrl_pkg
//   Shared definitions for the exception/eret commit controller:
//   - exception vector bit indices (CP0 ordering)
//   - default exception entry and outstanding-counter width
//   - FSM state encoding
// -----------------------------------------------------------------------------
package exc_commit_ctrl_pkg;

   // Bit positions inside the 8-bit exception vector {int,rine,rdae,ades,sys,bp,ri,ov}
   localparam int EXC_INT  = 7;
   localparam int EXC_RINE = 6;
   localparam int EXC_RDAE = 5;
   localparam int EXC_ADES = 4;
   localparam int EXC_SYS  = 3;
   localparam int EXC_BP   = 2;
   localparam int EXC_RI   = 1;
   localparam int EXC_OV   = 0;

   localparam logic [31:0] EXC_ENTRY_DEFAULT = 32'hbfc0_0380;  // BEV=1 vector
   localparam int          OST_W_DEFAULT     = 3;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_REPORT   = 2'd1,
      S_DRAIN    = 2'd2,
      S_REDIRECT = 2'd3
   } state_t;

endpackage : exc_commit_ctrl_pkg

// File: rtl/exc_commit_ctrl_if.sv
// -----------------------------------------------------------------------------
// exc_commit_ctrl_if
//   Bundles every signal of the commit controller except clk/rst.
//   master : the controller (consumes WB/CP0/bus status, drives CP0 report,
//            flush, request block and the IF redirect)
//   slave  : the surrounding pipeline / CP0 / IF
// Groups:
//   WB     : ws_valid, ws_exc[7:0], ws_eret, ws_pc, ws_is_slot, ws_bad_vaddr
//   CP0    : int_happen, cp0_epc (in); exc_type, exc_pc, exc_is_slot,
//            exc_bad_vaddr, eret (out)
//   bus    : mem_req_fire, mem_resp_fire (in); mem_req_block (out)
//   IF     : redirect_valid, redirect_pc (out); redirect_ready (in)
//   global : flush (out)
// -----------------------------------------------------------------------------
interface exc_commit_ctrl_if;

   logic        ws_valid;
   logic [7:0]  ws_exc;
   logic        ws_eret;
   logic [31:0] ws_pc;
   logic        ws_is_slot;
   logic [31:0] ws_bad_vaddr;
   logic        int_happen;
   logic [31:0] cp0_epc;
   logic        mem_req_fire;
   logic        mem_resp_fire;

   logic [7:0]  exc_type;
   logic [31:0] exc_pc;
   logic        exc_is_slot;
   logic [31:0] exc_bad_vaddr;
   logic        eret;
   logic        flush;
   logic        mem_req_block;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;

   modport master (
      input  ws_valid, ws_exc, ws_eret, ws_pc, ws_is_slot, ws_bad_vaddr,
      input  int_happen, cp0_epc, mem_req_fire, mem_resp_fire, redirect_ready,
      output exc_type, exc_pc, exc_is_slot, exc_bad_vaddr, eret, flush,
      output mem_req_block, redirect_valid, redirect_pc
   );

   modport slave (
      output ws_valid, ws_exc, ws_eret, ws_pc, ws_is_slot, ws_bad_vaddr,
      output int_happen, cp0_epc, mem_req_fire, mem_resp_fire, redirect_ready,
      input  exc_type, exc_pc, exc_is_slot, exc_bad_vaddr, eret, flush,
      input  mem_req_block, redirect_valid, redirect_pc
   );

endinterface : exc_commit_ctrl_if

// File: rtl/exc_commit_ctrl_ost_counter.sv
// -----------------------------------------------------------------------------
// exc_commit_ctrl_ost_counter
//   Outstanding data-bus transaction counter, OST_W bits, saturating at both
//   ends.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   inc       : request accepted by the bus
//   dec       : response returned
//   count     : current number of outstanding transactions
//   zero/full : count == 0 / count == 2**OST_W-1
// -----------------------------------------------------------------------------
module exc_commit_ctrl_ost_counter #(
   parameter int OST_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [OST_W-1:0] count,
   output logic             zero,
   output logic             full
);

   assign zero = (count == '0);
   assign full = (count == '1);

   // A simultaneous request and response cancel out; otherwise each edge is
   // ignored at the boundary it would cross, so the count never wraps.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && !dec && !full) begin
         count <= count + 1'b1;
      end else if (dec && !inc && !zero) begin
         count <= count - 1'b1;
      end
   end

endmodule : exc_commit_ctrl_ost_counter

// File: rtl/exc_commit_ctrl.sv
// -----------------------------------------------------------------------------
// exc_commit_ctrl
//   Commit-time exception/eret controller. Takes the exception flags of the
//   instruction in WB, reports it to CP0 for exactly one cycle, flushes the
//   pipeline, waits for outstanding data-bus transactions to drain and then
//   offers IF a redirect (exception entry, or CP0 EPC for eret).
// Parameters:
//   EXC_ENTRY : exception vector
//   OST_W     : outstanding-request counter width
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : exc_commit_ctrl_if.master (WB, CP0, data bus status, IF)
// -----------------------------------------------------------------------------
module exc_commit_ctrl
   import exc_commit_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEFAULT,
   parameter int          OST_W     = OST_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   exc_commit_ctrl_if.master  bus
);

   state_t           state;
   logic [7:0]       exc_type_q;
   logic             eret_q;
   logic [31:0]      exc_pc_q;
   logic             exc_is_slot_q;
   logic [31:0]      exc_bad_vaddr_q;
   logic             redirect_valid_q;
   logic [31:0]      redirect_pc_q;

   logic [OST_W-1:0] ost_count;
   logic             ost_zero;
   logic             ost_full;

   logic             accept;
   logic [7:0]       acc_vec;

   // WB's own int bit is meaningless; the interrupt comes from CP0.
   logic             unused_ws_int;
   assign unused_ws_int = bus.ws_exc[EXC_INT];

   assign acc_vec = {bus.int_happen, bus.ws_exc[EXC_INT-1:0]};
   // Only IDLE can accept, so ws_valid is implicitly ignored while flushing.
   assign accept  = (state == S_IDLE) && bus.ws_valid &&
                    ((|bus.ws_exc[EXC_INT-1:0]) || bus.int_happen || bus.ws_eret);

   exc_commit_ctrl_ost_counter #(
      .OST_W (OST_W)
   ) u_ost_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (bus.mem_req_fire),
      .dec   (bus.mem_resp_fire),
      .count (ost_count),
      .zero  (ost_zero),
      .full  (ost_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         exc_type_q       <= '0;
         eret_q           <= 1'b0;
         exc_pc_q         <= '0;
         exc_is_slot_q    <= 1'b0;
         exc_bad_vaddr_q  <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  // exc_type_q/eret_q are loaded here so they are high only
                  // during REPORT; an exception or interrupt beats eret.
                  exc_type_q      <= acc_vec;
                  eret_q          <= bus.ws_eret && (acc_vec == '0);
                  exc_pc_q        <= bus.ws_pc;
                  exc_is_slot_q   <= bus.ws_is_slot;
                  exc_bad_vaddr_q <= bus.ws_bad_vaddr;
                  state           <= S_REPORT;
               end
            end
            S_REPORT: begin
               // EPC is sampled here, the cycle CP0 sees the eret pulse.
               redirect_pc_q <= eret_q ? bus.cp0_epc : EXC_ENTRY;
               exc_type_q    <= '0;
               eret_q        <= 1'b0;
               state         <= S_DRAIN;
            end
            S_DRAIN: begin
               if (ost_zero) begin
                  redirect_valid_q <= 1'b1;
                  state            <= S_REDIRECT;
               end
            end
            S_REDIRECT: begin
               if (bus.redirect_ready) begin
                  redirect_valid_q <= 1'b0;
                  state            <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.exc_type       = exc_type_q;
   assign bus.eret           = eret_q;
   assign bus.exc_pc         = exc_pc_q;
   assign bus.exc_is_slot    = exc_is_slot_q;
   assign bus.exc_bad_vaddr  = exc_bad_vaddr_q;
   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;

   // Flush must kill younger stages in the very cycle the faulting
   // instruction commits, hence the combinational accept term.
   assign bus.flush         = accept || (state != S_IDLE);
   assign bus.mem_req_block = accept || (state != S_IDLE) || ost_full;

endmodule : exc_commit_ctrl
